ex_stage: RTL and testbench

Execute stage of the five-stage pipeline, the consumer end of the ID/EX pipeline register. It takes the decoded control and operand fields from ID/EX, performs the ALU operation, and computes the branch target and destination register. It registers the results into its own EX/MEM output register. MUL and DIVU run on an iterative 32-step datapath, and the block stalls ID/EX through a back-pressure handshake while one is in progress.

---
 rtl/ex_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage feeding the EX/MEM register (ALU, branch target, destination select).
// MUL/DIVU iterate over 32 cycles and stall ID/EX; define EX_DIV_EN to build the DIVU divider.
module ex_stage (
  input  logic        clkEX,
  input  logic        rstEX_n,
  input  logic        vIDEX,
  input  logic        flushEX,
  input  logic [1:0]  Wb1,
  input  logic [2:0]  Mem1,
  input  logic        RegDst,
  input  logic [2:0]  ALUOp,
  input  logic        ALUSrc,
  input  logic [31:0] tAdd,
  input  logic [31:0] tALU,
  input  logic [31:0] tMux32,
  input  logic [31:0] tACsl,
  input  logic [4:0]  tMux5_1,
  input  logic [4:0]  tMux5_2,
  output logic        stallEX,
  output logic        vEXMEM,
  output logic [1:0]  Wb2,
  output logic [2:0]  Mem2,
  output logic [31:0] ALURes,
  output logic        tZero,
  output logic [31:0] tBr,
  output logic [31:0] tWData,
  output logic [4:0]  tDest
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [2:0] {
    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_MUL, FN_DIVU, FN_ZERO
  } alu_fn_t;

  state_t      state;
  logic [4:0]  cnt;
  alu_fn_t     fn;
  logic        is_multi;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [31:0] br_target;
  logic [4:0]  dest;

  // Iterative datapath, shared by MUL and DIVU:
  // acc = partial product / remainder, shr = multiplier / dividend becoming quotient,
  // opnd = multiplicand (shifted left each step) / divisor.
  logic [31:0] acc, shr, opnd;
  logic [31:0] acc_nxt, shr_nxt, opnd_nxt;
  logic [31:0] iter_res;

  // Pass-through fields captured when a multi-cycle op starts.
  logic [1:0]  wb_l;
  logic [2:0]  mem_l;
  logic [31:0] br_l;
  logic [31:0] wdata_l;
  logic [4:0]  dest_l;

`ifdef EX_DIV_EN
  logic        it_div;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic        div_ok;
`endif

  assign op_b      = ALUSrc ? tACsl : tMux32;
  assign br_target = tAdd + {tACsl[29:0], 2'b00};
  assign dest      = RegDst ? tMux5_2 : tMux5_1;
  assign is_multi  = (fn == FN_MUL) || (fn == FN_DIVU);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fn = FN_ADD;
    case (ALUOp)
      3'b001: fn = FN_SUB;
      3'b011: fn = FN_AND;
      3'b100: fn = FN_OR;
      3'b101: fn = FN_SLT;
      3'b010: begin
        case (tACsl[5:0])
          6'h22:   fn = FN_SUB;
          6'h24:   fn = FN_AND;
          6'h25:   fn = FN_OR;
          6'h2A:   fn = FN_SLT;
          6'h18:   fn = FN_MUL;
`ifdef EX_DIV_EN
          6'h1A:   fn = FN_DIVU;
`else
          6'h1A:   fn = FN_ZERO;
`endif
          default: fn = FN_ADD;
        endcase
      end
      default: fn = FN_ADD;
    endcase
  end

  always_comb begin
    alu_res = tALU + op_b;
    case (fn)
      FN_SUB:  alu_res = tALU - op_b;
      FN_AND:  alu_res = tALU & op_b;
      FN_OR:   alu_res = tALU | op_b;
      FN_SLT:  alu_res = {31'd0, $signed(tALU) < $signed(op_b)};
      FN_ZERO: alu_res = 32'd0;
      default: alu_res = tALU + op_b;
    endcase
  end

  always_comb begin
    acc_nxt  = acc + (shr[0] ? opnd : 32'd0);
    shr_nxt  = shr >> 1;
    opnd_nxt = opnd << 1;
    iter_res = acc_nxt;
`ifdef EX_DIV_EN
    // Restoring step: a zero divisor always "fits", so the quotient saturates to all ones.
    rem_sh   = {acc, shr[31]};
    rem_diff = rem_sh - {1'b0, opnd};
    div_ok   = rem_sh >= {1'b0, opnd};
    if (it_div) begin
      acc_nxt  = div_ok ? rem_diff[31:0] : rem_sh[31:0];
      shr_nxt  = {shr[30:0], div_ok};
      opnd_nxt = opnd;
      iter_res = shr_nxt;
    end
`endif
  end

  // A flush cancels the request or the in-flight op, so it also releases ID/EX.
  assign stallEX = !flushEX &&
                   (((state == IDLE) && vIDEX && is_multi) ||
                    ((state == BUSY) && (cnt != 5'd31)));

  always_ff @(posedge clkEX or negedge rstEX_n) begin
    if (!rstEX_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      shr     <= '0;
      opnd    <= '0;
      wb_l    <= '0;
      mem_l   <= '0;
      br_l    <= '0;
      wdata_l <= '0;
      dest_l  <= '0;
      vEXMEM  <= 1'b0;
      Wb2     <= '0;
      Mem2    <= '0;
      ALURes  <= '0;
      tZero   <= 1'b0;
      tBr     <= '0;
      tWData  <= '0;
      tDest   <= '0;
`ifdef EX_DIV_EN
      it_div  <= 1'b0;
`endif
    end else begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (flushEX || !vIDEX) begin
            vEXMEM <= 1'b0;
            Wb2    <= '0;
            Mem2   <= '0;
          end else if (is_multi) begin
            vEXMEM  <= 1'b0;
            Wb2     <= '0;
            Mem2    <= '0;
            state   <= BUSY;
            cnt     <= '0;
            acc     <= '0;
            shr     <= tALU;
            opnd    <= op_b;
            wb_l    <= Wb1;
            mem_l   <= Mem1;
            br_l    <= br_target;
            wdata_l <= tMux32;
            dest_l  <= dest;
`ifdef EX_DIV_EN
            it_div  <= (fn == FN_DIVU);
`endif
          end else begin
            vEXMEM <= 1'b1;
            Wb2    <= Wb1;
            Mem2   <= Mem1;
            ALURes <= alu_res;
            tZero  <= (alu_res == 32'd0);
            tBr    <= br_target;
            tWData <= tMux32;
            tDest  <= dest;
          end
        end
        BUSY: begin
          if (flushEX) begin
            vEXMEM <= 1'b0;
            Wb2    <= '0;
            Mem2   <= '0;
            state  <= IDLE;
            cnt    <= '0;
          end else if (cnt == 5'd31) begin
            vEXMEM <= 1'b1;
            Wb2    <= wb_l;
            Mem2   <= mem_l;
            ALURes <= iter_res;
            tZero  <= (iter_res == 32'd0);
            tBr    <= br_l;
            tWData <= wdata_l;
            tDest  <= dest_l;
            state  <= IDLE;
            cnt    <= '0;
          end else begin
            acc  <= acc_nxt;
            shr  <= shr_nxt;
            opnd <= opnd_nxt;
            cnt  <= cnt + 5'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed checks of ex_stage against a transaction-level model
// (plain arithmetic results, 32 stall cycles for MUL/DIVU, flush and reset behaviour).
module tb_ex_stage;

  logic        clkEX = 1'b0;
  logic        rstEX_n = 1'b1;
  logic        vIDEX = 1'b0;
  logic        flushEX = 1'b0;
  logic [1:0]  Wb1 = '0;
  logic [2:0]  Mem1 = '0;
  logic        RegDst = 1'b0;
  logic [2:0]  ALUOp = '0;
  logic        ALUSrc = 1'b0;
  logic [31:0] tAdd = '0, tALU = '0, tMux32 = '0, tACsl = '0;
  logic [4:0]  tMux5_1 = '0, tMux5_2 = '0;
  logic        stallEX, vEXMEM, tZero;
  logic [1:0]  Wb2;
  logic [2:0]  Mem2;
  logic [31:0] ALURes, tBr, tWData;
  logic [4:0]  tDest;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        v;
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic        regdst;
    logic [2:0]  aluop;
    logic        alusrc;
    logic [31:0] tadd, a, rtd, imm;
    logic [4:0]  rt, rd;
  } op_t;

  ex_stage dut (
    .clkEX(clkEX), .rstEX_n(rstEX_n), .vIDEX(vIDEX), .flushEX(flushEX),
    .Wb1(Wb1), .Mem1(Mem1), .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
    .tAdd(tAdd), .tALU(tALU), .tMux32(tMux32), .tACsl(tACsl),
    .tMux5_1(tMux5_1), .tMux5_2(tMux5_2),
    .stallEX(stallEX), .vEXMEM(vEXMEM), .Wb2(Wb2), .Mem2(Mem2), .ALURes(ALURes),
    .tZero(tZero), .tBr(tBr), .tWData(tWData), .tDest(tDest)
  );

  always #5 clkEX = ~clkEX;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Result and stall length of one instruction, straight from the operation table.
  function automatic void model(input op_t o, output logic [31:0] res, output int stalls);
    logic [31:0] b;
    b = o.alusrc ? o.imm : o.rtd;
    stalls = 0;
    case (o.aluop)
      3'd1: res = o.a - b;
      3'd3: res = o.a & b;
      3'd4: res = o.a | b;
      3'd5: res = ($signed(o.a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd2: begin
        case (o.imm[5:0])
          6'h22: res = o.a - b;
          6'h24: res = o.a & b;
          6'h25: res = o.a | b;
          6'h2A: res = ($signed(o.a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h18: begin res = o.a * b; stalls = 32; end
`ifdef EX_DIV_EN
          6'h1A: begin res = (b == 0) ? 32'hFFFF_FFFF : o.a / b; stalls = 32; end
`else
          6'h1A: res = 32'd0;
`endif
          default: res = o.a + b;
        endcase
      end
      default: res = o.a + b;
    endcase
    if (!o.v) stalls = 0;
  endfunction

  function automatic op_t mk_op(input logic [2:0] aluop, input logic alusrc,
                                input logic [31:0] a, input logic [31:0] rtd,
                                input logic [31:0] imm);
    op_t o;
    o.v = 1'b1; o.wb = 2'b11; o.mem = 3'b101; o.regdst = 1'b0;
    o.aluop = aluop; o.alusrc = alusrc; o.tadd = 32'h400;
    o.a = a; o.rtd = rtd; o.imm = imm; o.rt = 5'd7; o.rd = 5'd9;
    return o;
  endfunction

  task automatic drive(input op_t o);
    vIDEX = o.v; Wb1 = o.wb; Mem1 = o.mem; RegDst = o.regdst; ALUOp = o.aluop;
    ALUSrc = o.alusrc; tAdd = o.tadd; tALU = o.a; tMux32 = o.rtd; tACsl = o.imm;
    tMux5_1 = o.rt; tMux5_2 = o.rd;
  endtask

  // Present one instruction, count stall cycles (bounded), then check the EX/MEM write.
  task automatic exec(input op_t o);
    logic [31:0] er;
    int es;
    int n;
    model(o, er, es);
    drive(o);
    #1;
    n = 0;
    while (stallEX && n < 40) begin
      @(posedge clkEX); #1;
      check("busy_valid", {31'd0, vEXMEM}, 32'd0);
      n++;
    end
    check("stall_cycles", n, es);
    @(posedge clkEX); #1;
    check("valid", {31'd0, vEXMEM}, {31'd0, o.v});
    if (o.v) begin
      check("alures", ALURes, er);
      check("zero", {31'd0, tZero}, {31'd0, er == 32'd0});
      check("br", tBr, o.tadd + (o.imm << 2));
      check("wdata", tWData, o.rtd);
      check("dest", {27'd0, tDest}, {27'd0, o.regdst ? o.rd : o.rt});
      check("wb", {30'd0, Wb2}, {30'd0, o.wb});
      check("mem", {29'd0, Mem2}, {29'd0, o.mem});
    end
  endtask

  initial begin
    op_t o;
    logic [5:0] fn_tab [8];

    #1 rstEX_n = 1'b0;
    #1;
    check("rst_v", {31'd0, vEXMEM}, 32'd0);
    check("rst_wb", {30'd0, Wb2}, 32'd0);
    check("rst_mem", {29'd0, Mem2}, 32'd0);
    check("rst_res", ALURes, 32'd0);
    check("rst_zero", {31'd0, tZero}, 32'd0);
    check("rst_br", tBr, 32'd0);
    check("rst_wdata", tWData, 32'd0);
    check("rst_dest", {27'd0, tDest}, 32'd0);
    check("rst_stall", {31'd0, stallEX}, 32'd0);
    #10 rstEX_n = 1'b1;
    @(posedge clkEX); #1;

    o = mk_op(3'd2, 1'b0, 32'd5, 32'd7, 32'h0000_0022);
    exec(o);
    check("sub_res", ALURes, 32'hFFFF_FFFE);
    check("sub_zero", {31'd0, tZero}, 32'd0);
    o = mk_op(3'd1, 1'b0, 32'd9, 32'd9, 32'h0000_0123);
    exec(o);
    check("eq_zero", {31'd0, tZero}, 32'd1);
    o = mk_op(3'd0, 1'b0, 32'd1, 32'd2, 32'hFFFF_FFFF);
    o.tadd = 32'h100;
    exec(o);
    check("br_neg", tBr, 32'h0000_00FC);
    o = mk_op(3'd0, 1'b1, 32'd8, 32'd55, 32'd4);
    o.regdst = 1'b1; o.rd = 5'd13; o.wb = 2'b11; o.mem = 3'b010;
    exec(o);
    check("rd_dest", {27'd0, tDest}, 32'd13);
    check("imm_res", ALURes, 32'd12);
    check("pass_wb", {30'd0, Wb2}, 32'd3);
    check("pass_mem", {29'd0, Mem2}, 32'd2);
    o = mk_op(3'd2, 1'b0, 32'h0001_0000, 32'h0003_0001, 32'h0000_0018);
    exec(o);
    check("mul_res", ALURes, 32'h0001_0000);
    exec(o);
    o = mk_op(3'd2, 1'b0, 32'd100, 32'd7, 32'h0000_001A);
    exec(o);
`ifdef EX_DIV_EN
    check("divu_res", ALURes, 32'd14);
`else
    check("divu_off_res", ALURes, 32'd0);
`endif
    o = mk_op(3'd2, 1'b0, 32'd100, 32'd0, 32'h0000_001A);
    exec(o);

    // Flush in IDLE on a single-cycle op.
    o = mk_op(3'd0, 1'b0, 32'd3, 32'd4, 32'd0);
    drive(o); flushEX = 1'b1;
    @(posedge clkEX); #1;
    flushEX = 1'b0;
    check("flush_idle_v", {31'd0, vEXMEM}, 32'd0);
    check("flush_idle_wb", {30'd0, Wb2}, 32'd0);
    check("flush_idle_mem", {29'd0, Mem2}, 32'd0);

    // Flush a MUL at cnt == 5; the following add must be single-cycle.
    o = mk_op(3'd2, 1'b0, 32'd123, 32'd456, 32'h0000_0018);
    drive(o);
    repeat (6) @(posedge clkEX);
    #1;
    check("pre_flush_stall", {31'd0, stallEX}, 32'd1);
    flushEX = 1'b1;
    #1;
    check("flush_busy_stall", {31'd0, stallEX}, 32'd0);
    @(posedge clkEX); #1;
    flushEX = 1'b0;
    check("flush_busy_v", {31'd0, vEXMEM}, 32'd0);
    check("flush_busy_wb", {30'd0, Wb2}, 32'd0);
    o = mk_op(3'd0, 1'b0, 32'd20, 32'd22, 32'd0);
    exec(o);
    check("after_flush_res", ALURes, 32'd42);

    // Flush coinciding with completion: bubble wins.
    o = mk_op(3'd2, 1'b0, 32'd6, 32'd7, 32'h0000_0018);
    drive(o);
    repeat (32) @(posedge clkEX);
    #1;
    check("last_cycle_stall", {31'd0, stallEX}, 32'd0);
    flushEX = 1'b1;
    @(posedge clkEX); #1;
    flushEX = 1'b0;
    check("flush_last_v", {31'd0, vEXMEM}, 32'd0);

    fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24; fn_tab[3] = 6'h25;
    fn_tab[4] = 6'h2A; fn_tab[5] = 6'h18; fn_tab[6] = 6'h1A; fn_tab[7] = 6'h3F;
    for (int i = 0; i < 40; i++) begin
      o.v = ($urandom_range(0, 9) != 0);
      o.wb = 2'($urandom); o.mem = 3'($urandom); o.regdst = 1'($urandom);
      o.aluop = 3'($urandom); o.alusrc = 1'($urandom);
      o.tadd = $urandom; o.a = $urandom; o.rtd = $urandom; o.imm = $urandom;
      o.rt = 5'($urandom); o.rd = 5'($urandom);
      if ($urandom_range(0, 1) == 1) o.aluop = 3'd2;
      if (o.aluop == 3'd2) o.imm[5:0] = fn_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) o.rtd = $urandom_range(0, 20);
      exec(o);
    end

    // Reset in the middle of a MUL at cnt == 10.
    o = mk_op(3'd0, 1'b0, 32'd1, 32'd2, 32'd1);
    exec(o);
    o = mk_op(3'd2, 1'b0, 32'd77, 32'd99, 32'h0000_0018);
    drive(o);
    repeat (11) @(posedge clkEX);
    #1;
    check("mid_mul_stall", {31'd0, stallEX}, 32'd1);
    rstEX_n = 1'b0;
    vIDEX = 1'b0;
    #1;
    check("mrst_stall", {31'd0, stallEX}, 32'd0);
    check("mrst_v", {31'd0, vEXMEM}, 32'd0);
    check("mrst_wb", {30'd0, Wb2}, 32'd0);
    check("mrst_mem", {29'd0, Mem2}, 32'd0);
    check("mrst_res", ALURes, 32'd0);
    check("mrst_zero", {31'd0, tZero}, 32'd0);
    check("mrst_br", tBr, 32'd0);
    check("mrst_wdata", tWData, 32'd0);
    check("mrst_dest", {27'd0, tDest}, 32'd0);
    @(posedge clkEX); #3;
    rstEX_n = 1'b1;
    @(posedge clkEX); #1;
    o = mk_op(3'd4, 1'b1, 32'h0000_F000, 32'd0, 32'h0000_000F);
    exec(o);
    o = mk_op(3'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0018);
    exec(o);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
